hs_reg_slice: RTL
=================

// Module: hs_reg_slice
//
// PURPOSE
//   Parametrised valid/ready register slice placed between handshake_master and
//   handshake_slave. It replaces the fixed valid_beat/ready_beat pair: one
//   module that breaks the forward path, the backward path, or both. Full mode
//   uses a 2-entry skid buffer, so throughput stays at 1 beat/cycle.
//   Data order is preserved. No beat is ever dropped or duplicated.
//
// PARAMETERS
//   DATA_W  32  width of data_up/data_down
//   MODE    3   0=pass-through, 1=forward (valid/data registered),
//               2=backward (ready registered), 3=full (both registered)
//
// PORTS
//   clk         in   1       single clock, rising edge
//   rst_n       in   1       asynchronous, active-low reset
//   data_up     in   DATA_W  payload from upstream (master side)
//   valid_up    in   1       upstream valid
//   ready_up    out  1       ready returned to upstream
//   data_down   out  DATA_W  payload to downstream (slave side)
//   valid_down  out  1       downstream valid
//   ready_down  in   1       downstream ready
//   occupancy   out  2       number of beats held inside the slice (0..2)
//
// BEHAVIOUR
//   - A transfer happens on a rising edge when valid && ready on that side.
//     Upstream may not withdraw valid_up or change data_up while stalled;
//     the slice obeys the same rule on its downstream side.
//   - Reset (async assert, sync release): all valid/skid flags=0, data regs=0,
//     valid_down=0, occupancy=0. ready_up=0 while rst_n=0; after release:
//     MODE0 follows ready_down, MODE1/2/3 =1.
//     Reset asserted mid-transfer discards held beats; nothing is replayed.
//   - MODE0: wires only. data_down=data_up, valid_down=valid_up,
//     ready_up=ready_down. occupancy=0. Latency 0.
//   - MODE1: one register stage (main_v, main_d).
//     ready_up = ~main_v | ready_down (combinational from ready_down).
//     Load main on an upstream transfer; clear main_v on a downstream transfer
//     with no load in the same cycle. valid_down=main_v, data_down=main_d.
//     Latency 1. Full rate when ready_down is held 1.
//   - MODE2: skid register (skid_v, skid_d). ready_up = ~skid_v (registered).
//     valid_down = valid_up | skid_v; data_down = skid_v ? skid_d : data_up.
//     Set skid on valid_up && ready_up && ~ready_down. Clear skid on ready_down.
//     Latency 0.
//   - MODE3: FSM over {main, skid}.
//       EMPTY (occ 0): upstream transfer -> BUSY.
//       BUSY  (occ 1): in&out -> BUSY (main reloaded); in only -> FULL (beat to
//                      skid); out only -> EMPTY.
//       FULL  (occ 2): ready_up=0. On ready_down: skid->main, -> BUSY.
//     ready_up = ~skid_v (registered). valid_down=main_v. Latency 1.
//     Sustained 1 beat/cycle. No combinational path in either direction.
//   - Simultaneous in/out: output register takes the new beat in the same edge.
//     Nothing is lost at the EMPTY/FULL boundaries.
//   - occupancy: MODE1 = main_v; MODE2 = skid_v; MODE3 = main_v + skid_v.
//   - Any other MODE value: elaboration error ($error in generate).
//
// TESTING (run every MODE 0..3 unless a scenario names one)
//   1 Reset: rst_n=0 mid-stream with occ=2 -> same cycle valid_down=0, occ=0,
//     ready_up=0. After release, ready_up=1 (MODE1-3).
//   2 Streaming: send 0x1..0x100, valid_up=1, ready_down=1 ->
//     out 0x1..0x100 in order, one per cycle. First beat after 0 cycles
//     (MODE0/2) or 1 cycle (MODE1/3).
//   3 MODE3 back-pressure: drop ready_down with 0xA,0xB in flight ->
//     occ=2, ready_up=0 next cycle. Raise ready_down -> 0xA then 0xB
//     back-to-back.
//   4 MODE2 skid: ready_down=0 in the cycle 0xC5 is accepted -> skid_v=1,
//     ready_up=0. data_down=0xC5 held until ready_down=1.
//   5 Random valid_up/ready_down, 10k beats, scoreboard: no loss/dup/reorder.
//     Assertion: data_down stable while valid_down && ~ready_down.
//   6 Walking-ones data with DATA_W=8 and DATA_W=64 -> bit-exact.

Source files
------------

// File: rtl/hs_reg_slice.sv
// Valid/ready register slice: MODE picks pass-through, forward, backward or full (2-entry skid) registering.
// Latency 0 (MODE0/2) or 1 (MODE1/3); ready_up drops only when the slice holds a beat it cannot yet pass on.
module hs_reg_slice #(
  parameter int DATA_W = 32,
  parameter int MODE   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_up,
  input  logic              valid_up,
  output logic              ready_up,
  output logic [DATA_W-1:0] data_down,
  output logic              valid_down,
  input  logic              ready_down,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  if (MODE == 0) begin : g_pass
    // Both handshake signals are forced low while reset is held.
    assign data_down  = data_up;
    assign valid_down = valid_up & rst_n;
    assign ready_up   = ready_down & rst_n;
    assign occupancy  = 2'd0;

  end else if (MODE == 1) begin : g_fwd
    logic              main_v_q, main_v_d;
    logic [DATA_W-1:0] main_dat_q, main_dat_d;
    logic              in_xfer, out_xfer;

    assign ready_up = rst_n & (~main_v_q | ready_down);
    assign in_xfer  = valid_up & ready_up;
    assign out_xfer = main_v_q & ready_down;

    always_comb begin
      main_v_d   = main_v_q;
      main_dat_d = main_dat_q;
      if (in_xfer) begin
        main_v_d   = 1'b1;
        main_dat_d = data_up;
      end else if (out_xfer) begin
        main_v_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_v_q   <= 1'b0;
        main_dat_q <= '0;
      end else begin
        main_v_q   <= main_v_d;
        main_dat_q <= main_dat_d;
      end
    end

    assign valid_down = main_v_q;
    assign data_down  = main_dat_q;
    assign occupancy  = {1'b0, main_v_q};

  end else if (MODE == 2) begin : g_bwd
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] skid_dat_q, skid_dat_d;

    assign ready_up = rst_n & ~skid_v_q;

    // A beat accepted while downstream stalls parks in the skid register.
    always_comb begin
      skid_v_d   = skid_v_q;
      skid_dat_d = skid_dat_q;
      if (ready_down) begin
        skid_v_d = 1'b0;
      end else if (valid_up && ready_up) begin
        skid_v_d   = 1'b1;
        skid_dat_d = data_up;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_v_q   <= 1'b0;
        skid_dat_q <= '0;
      end else begin
        skid_v_q   <= skid_v_d;
        skid_dat_q <= skid_dat_d;
      end
    end

    assign valid_down = rst_n & (valid_up | skid_v_q);
    assign data_down  = skid_v_q ? skid_dat_q : data_up;
    assign occupancy  = {1'b0, skid_v_q};

  end else if (MODE == 3) begin : g_full
    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_dat_q, main_dat_d;
    logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
    logic              main_v, skid_v;
    logic              in_xfer, out_xfer;

    assign main_v   = (state_q != S_EMPTY);
    assign skid_v   = (state_q == S_FULL);
    assign ready_up = rst_n & ~skid_v;
    assign in_xfer  = valid_up & ready_up;
    assign out_xfer = main_v & ready_down;

    always_comb begin
      state_d    = state_q;
      main_dat_d = main_dat_q;
      skid_dat_d = skid_dat_q;
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d    = S_BUSY;
            main_dat_d = data_up;
          end
        end
        S_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_dat_d = data_up;
          end else if (in_xfer) begin
            state_d    = S_FULL;
            skid_dat_d = data_up;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // ready_up is low here, so only the drain side can move.
          if (out_xfer) begin
            state_d    = S_BUSY;
            main_dat_d = skid_dat_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= S_EMPTY;
        main_dat_q <= '0;
        skid_dat_q <= '0;
      end else begin
        state_q    <= state_d;
        main_dat_q <= main_dat_d;
        skid_dat_q <= skid_dat_d;
      end
    end

    assign valid_down = main_v;
    assign data_down  = main_dat_q;
    assign occupancy  = {1'b0, main_v} + {1'b0, skid_v};

  end else begin : g_bad
    $error("hs_reg_slice: unsupported MODE %0d", MODE);
    assign data_down  = '0;
    assign valid_down = 1'b0;
    assign ready_up   = 1'b0;
    assign occupancy  = 2'd0;
  end

endmodule
